memory_stage_bus: RTL and testbench

- Memory pipeline stage. Consumes the ALU result, store data, destination register and control produced by the execute stage.
- Owns the E->M pipeline register and drives a valid/ack data-memory bus.
- Returns forwarding and stall information to the hazard unit.
- Absorbs variable memory latency by stalling the pipeline; aborts an access on bus timeout.

---
 rtl/memory_stage_bus.sv | 128 ++++++++++++
 tb/tb_memory_stage_bus.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_bus.sv
// Memory pipeline stage: E->M pipeline register, valid/ack data-memory bus
// master with timeout abort, and stall/forwarding outputs for the hazard unit.
module memory_stage_bus #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [31:0] i_ALUResultE,
    input  logic [31:0] i_WriteDataE,
    input  logic [4:0]  i_RdE,
    input  logic [31:0] i_PCPlus4E,
    input  logic        i_RegWriteE,
    input  logic [1:0]  i_ResultSrcE,
    input  logic        i_MemWriteE,
    output logic [31:0] o_ALUResultM,
    output logic [4:0]  o_RdM,
    output logic        o_RegWriteM,
    output logic        o_StallM,
    output logic        o_BusErrM,
    output logic        o_DReq,
    output logic        o_DWe,
    output logic [31:0] o_DAddr,
    output logic [31:0] o_DWData,
    input  logic        i_DAck,
    input  logic [31:0] i_DRData,
    output logic [31:0] o_ReadDataM,
    output logic [31:0] o_PCPlus4M,
    output logic [1:0]  o_ResultSrcM,
    output logic        o_WBEnM
);

    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] pc4_q;
    logic        regwrite_q;
    logic [1:0]  resultsrc_q;
    logic        memwrite_q;

    logic        access;
    logic        abort;
    logic        stall;
    logic        memop_e;
    logic        load_m;

    // Access status: an ack in the same cycle beats a coincident timeout
    always_comb begin
        access  = (state_q == ACCESS);
        abort   = access & ~i_DAck & (cnt_q == CNT_MAX);
        stall   = access & ~i_DAck & ~abort;
        memop_e = i_MemWriteE | (i_ResultSrcE == RS_LOAD);
        load_m  = (resultsrc_q == RS_LOAD);
    end

    // Next state: stalled accesses hold; otherwise the newly captured
    // instruction decides whether a bus access starts on the next cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bus_err_d = bus_err_q | abort;
        if (stall) begin
            state_d = ACCESS;
            cnt_d   = cnt_q + 8'd1;
        end else begin
            state_d = memop_e ? ACCESS : IDLE;
        end
    end

    // Sequential state: FSM, wait counter, sticky error and the M register
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
            alu_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            pc4_q       <= '0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            memwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            if (!stall) begin
                alu_q       <= i_ALUResultE;
                wdata_q     <= i_WriteDataE;
                rd_q        <= i_RdE;
                pc4_q       <= i_PCPlus4E;
                regwrite_q  <= i_RegWriteE;
                resultsrc_q <= i_ResultSrcE;
                memwrite_q  <= i_MemWriteE;
            end
        end
    end

    // Bus drive and writeback outputs; bus fields are zeroed when idle
    always_comb begin
        o_DReq      = access;
        o_DAddr     = access ? alu_q   : '0;
        o_DWData    = access ? wdata_q : '0;
        o_DWe       = access & memwrite_q;
        o_StallM    = stall;
        o_ReadDataM = (access & i_DAck & load_m) ? i_DRData : '0;
        o_WBEnM     = regwrite_q & ~stall;
    end

    assign o_ALUResultM = alu_q;
    assign o_RdM        = rd_q;
    assign o_RegWriteM  = regwrite_q;
    assign o_PCPlus4M   = pc4_q;
    assign o_ResultSrcM = resultsrc_q;
    assign o_BusErrM    = bus_err_q;

endmodule

// File: tb/tb_memory_stage_bus.sv
// Self-checking bench for memory_stage_bus: directed scenarios plus random
// traffic compared against a transaction-level model of the M stage.
module tb_memory_stage_bus;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_e, wd_e, pc4_e;
    logic [4:0]  rd_e;
    logic        rw_e, mw_e;
    logic [1:0]  rs_e;
    logic [31:0] alu_m, daddr, dwdata, drdata, rdata_m, pc4_m;
    logic [4:0]  rd_m;
    logic        rw_m, stall_m, buserr_m, dreq, dwe, dack, wben_m;
    logic [1:0]  rs_m;

    memory_stage_bus #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst_n),
        .i_ALUResultE (alu_e),
        .i_WriteDataE (wd_e),
        .i_RdE        (rd_e),
        .i_PCPlus4E   (pc4_e),
        .i_RegWriteE  (rw_e),
        .i_ResultSrcE (rs_e),
        .i_MemWriteE  (mw_e),
        .o_ALUResultM (alu_m),
        .o_RdM        (rd_m),
        .o_RegWriteM  (rw_m),
        .o_StallM     (stall_m),
        .o_BusErrM    (buserr_m),
        .o_DReq       (dreq),
        .o_DWe        (dwe),
        .o_DAddr      (daddr),
        .o_DWData     (dwdata),
        .i_DAck       (dack),
        .i_DRData     (drdata),
        .o_ReadDataM  (rdata_m),
        .o_PCPlus4M   (pc4_m),
        .o_ResultSrcM (rs_m),
        .o_WBEnM      (wben_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the instruction held in M, whether its bus access is still
    // outstanding, how many unacknowledged cycles it has waited, and the error flag.
    typedef struct {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } instr_t;

    instr_t      m;
    bit          pending;
    int unsigned waited;
    bit          err;

    int unsigned stall_seen;
    int unsigned req_seen;
    logic [31:0] addr_log[$];

    function automatic bit is_memop(input logic mw, input logic [1:0] rs);
        return mw || (rs == 2'b01);
    endfunction

    task automatic model_reset();
        m       = '{alu: '0, wd: '0, pc4: '0, rd: '0, rw: 1'b0, mw: 1'b0, rs: '0};
        pending = 1'b0;
        waited  = 0;
        err     = 1'b0;
    endtask

    // One pipeline cycle: drive E-side and bus inputs, check at negedge, advance model.
    task automatic cyc(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic ack, input logic [31:0] rdat);
        bit          timed_out, stall;
        logic [31:0] exp_rd;
        alu_e = alu; wd_e = wd; pc4_e = pc4; rd_e = rd; rw_e = rw; rs_e = rs; mw_e = mw;
        dack = ack; drdata = rdat;

        timed_out = pending && !ack && (waited == TO - 1);
        stall     = pending && !ack && !timed_out;
        exp_rd    = (pending && ack && m.rs == 2'b01) ? rdat : 32'h0;

        @(negedge clk);
        check("dreq",    32'(dreq),     32'(pending));
        check("dwe",     32'(dwe),      32'(pending && m.mw));
        check("daddr",   daddr,         pending ? m.alu : 32'h0);
        check("dwdata",  dwdata,        pending ? m.wd  : 32'h0);
        check("stall",   32'(stall_m),  32'(stall));
        check("rdata",   rdata_m,       exp_rd);
        check("wben",    32'(wben_m),   32'(m.rw && !stall));
        check("buserr",  32'(buserr_m), 32'(err));
        check("alu_m",   alu_m,         m.alu);
        check("rd_m",    32'(rd_m),     32'(m.rd));
        check("rw_m",    32'(rw_m),     32'(m.rw));
        check("pc4_m",   pc4_m,         m.pc4);
        check("rs_m",    32'(rs_m),     32'(m.rs));
        if (stall_m) stall_seen++;
        if (dreq) begin
            req_seen++;
            addr_log.push_back(daddr);
        end

        if (stall) begin
            waited++;
        end else begin
            if (timed_out) err = 1'b1;
            m       = '{alu: alu, wd: wd, pc4: pc4, rd: rd, rw: rw, mw: mw, rs: rs};
            pending = is_memop(mw, rs);
            waited  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic ack);
        cyc(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, ack, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_e = '0; wd_e = '0; pc4_e = '0; rd_e = '0; rw_e = 1'b0; rs_e = '0; mw_e = 1'b0;
        dack = 1'b0; drdata = '0;
        do_reset();

        // Reset state
        check("rst_dreq",   32'(dreq),     32'd0);
        check("rst_stall",  32'(stall_m),  32'd0);
        check("rst_wben",   32'(wben_m),   32'd0);
        check("rst_buserr", 32'(buserr_m), 32'd0);

        // ALU op passes through in one cycle
        cyc(32'h1234, 32'h0, 32'h4, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        nop(1'b0);
        check("alu_1234", alu_m, 32'h0);

        // Load with same-cycle ack: one request cycle, no stall
        stall_seen = 0; req_seen = 0;
        cyc(32'h100, 32'h0, 32'h8, 5'd6, 1'b1, 2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
        cyc(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
        nop(1'b1);
        check("ld0_reqs",   req_seen,   32'd1);
        check("ld0_stalls", stall_seen, 32'd0);

        // Store acked three cycles after the request
        stall_seen = 0;
        cyc(32'h200, 32'hCAFEF00D, 32'hC, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        nop(1'b0); nop(1'b0); nop(1'b0);
        cyc(32'h44, 32'h0, 32'h10, 5'd7, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0);
        nop(1'b0);
        check("st_stalls", stall_seen, 32'd3);

        // Load, store, load back-to-back with zero wait
        req_seen = 0; addr_log.delete();
        cyc(32'h300, 32'h0, 32'h0, 5'd1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h11);
        cyc(32'h304, 32'h55, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h22);
        cyc(32'h308, 32'h0, 32'h0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b1, 32'h33);
        cyc(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h44);
        nop(1'b1);
        check("b2b_reqs", req_seen, 32'd3);
        if (addr_log.size() == 3) begin
            check("b2b_a0", addr_log[0], 32'h300);
            check("b2b_a1", addr_log[1], 32'h304);
            check("b2b_a2", addr_log[2], 32'h308);
        end else begin
            check("b2b_log", 32'(addr_log.size()), 32'd3);
        end

        // Load that is never acknowledged: timeout abort, sticky error
        stall_seen = 0;
        cyc(32'h400, 32'h0, 32'h0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
        for (int unsigned i = 0; i < TO + 4; i++) nop(1'b0);
        check("to_stalls", stall_seen, 32'(TO - 1));
        check("to_err",    32'(buserr_m), 32'd1);

        // Reset asserted in the second wait cycle of a load
        cyc(32'h500, 32'h0, 32'h0, 5'd4, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
        nop(1'b0);
        dack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dreq",   32'(dreq),     32'd0);
        check("mid_rst_stall",  32'(stall_m),  32'd0);
        check("mid_rst_buserr", 32'(buserr_m), 32'd0);
        do_reset();
        stall_seen = 0;
        cyc(32'h600, 32'h0, 32'h0, 5'd8, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
        nop(1'b0);
        cyc(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h600D);
        nop(1'b0);
        check("post_rst_stalls", stall_seen, 32'd1);

        // Random traffic: frequent acks, then sparse acks to reach timeouts
        for (int unsigned ph = 0; ph < 2; ph++) begin
            int unsigned ackdiv;
            ackdiv = (ph == 0) ? 2 : 14;
            for (int unsigned i = 0; i < 1500; i++) begin
                cyc($urandom, $urandom, $urandom, 5'($urandom),
                    1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, ackdiv - 1) == 0), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
